// File: rtl/mem_access_pkg.sv
// Shared width codes, FSM states and helpers for the MEM-stage data memory.
package mem_access_pkg;

    localparam logic [1:0] WIDTH_WORD = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_BYTE = 2'd2;

    // Wait counter holds WAIT_STATES-2, so 4 bits covers the 0..15 range.
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [31:0] sext8(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: load extraction with sign extension, store
// byte mask and lane-replicated store word, plus alignment check.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  i_width,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_wword,
    output logic [3:0]  o_wmask,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte     = i_rword[8*i_addr_lo +: 8];
        w_half     = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
        o_load     = '0;
        o_wword    = '0;
        o_wmask    = '0;
        o_misalign = 1'b0;
        case (i_width)
            WIDTH_WORD: begin
                o_load     = i_rword;
                o_wword    = i_wdata;
                o_wmask    = 4'b1111;
                o_misalign = (i_addr_lo != 2'b00);
            end
            WIDTH_HALF: begin
                o_load     = sext16(w_half);
                o_wword    = {2{i_wdata[15:0]}};
                o_wmask    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_misalign = i_addr_lo[0];
            end
            WIDTH_BYTE: begin
                o_load     = sext8(w_byte);
                o_wword    = {4{i_wdata[7:0]}};
                o_wmask    = 4'b0001 << i_addr_lo;
            end
            default: o_misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory responder with configurable wait states, pipeline
// stall, completion pulse and rejection of misaligned/illegal requests.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        R_Enable,
    input  logic        W_Enable,
    input  logic [1:0]  R_Width,
    input  logic [1:0]  W_Width,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Valid,
    output logic        MisalignErr
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned AW    = IDX_W + 2;
    localparam bit NO_WAIT  = (WAIT_STATES == 0);
    localparam bit ONE_SHOT = (WAIT_STATES <= 1);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_STATES >= 2) ? CNT_W'(WAIT_STATES - 2) : '0;

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [AW-1:0]    r_addr;
    logic [31:0]      r_wdata;
    logic [1:0]       r_width;
    logic             r_we;
    logic [31:0]      r_rdata;
    logic             r_valid;
    logic             r_misalign;
    logic [31:0]      r_mem [DEPTH_WORDS] = '{default: '0};

    logic             w_in_wait, w_req, w_illegal, w_accept, w_commit;
    logic [AW-1:0]    w_sel_addr;
    logic [31:0]      w_sel_wdata;
    logic [1:0]       w_sel_width;
    logic             w_sel_we;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rword, w_load, w_wword;
    logic [3:0]       w_wmask;
    logic             w_misalign;
    logic             w_unused_addr;

    assign w_unused_addr = ^Address[31:AW];

    // While waiting, the latched request drives the datapath, not the live inputs.
    always_comb begin
        w_in_wait   = (r_state == WAIT);
        w_sel_addr  = w_in_wait ? r_addr  : Address[AW-1:0];
        w_sel_wdata = w_in_wait ? r_wdata : WriteData;
        w_sel_we    = w_in_wait ? r_we    : W_Enable;
        w_sel_width = w_in_wait ? r_width : (W_Enable ? W_Width : R_Width);
        w_idx       = w_sel_addr[AW-1:2];
        w_rword     = r_mem[w_idx];
    end

    mem_lane_align u_lane (
        .i_width    (w_sel_width),
        .i_addr_lo  (w_sel_addr[1:0]),
        .i_rword    (w_rword),
        .i_wdata    (w_sel_wdata),
        .o_load     (w_load),
        .o_wword    (w_wword),
        .o_wmask    (w_wmask),
        .o_misalign (w_misalign)
    );

    always_comb begin
        w_req     = R_Enable | W_Enable;
        w_illegal = (R_Enable & W_Enable) | w_misalign;
        w_accept  = ~Rst & (r_state == IDLE) & w_req & ~w_illegal;
        w_commit  = ~Rst & ((w_accept & ONE_SHOT) | (w_in_wait & (r_cnt == '0)));
        Stall     = ~Rst & ((w_accept & ~NO_WAIT) | w_in_wait);
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept && !NO_WAIT) begin
                    if (ONE_SHOT) begin
                        w_state_nx = DONE;
                    end else begin
                        w_state_nx = WAIT;
                        w_cnt_nx   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) w_state_nx = DONE;
                else             w_cnt_nx   = r_cnt - 1'b1;
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_valid    <= w_commit;
            r_misalign <= (r_state == IDLE) & w_req & w_illegal;
            if (w_commit && !w_sel_we) r_rdata <= w_load;
        end
    end

    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_addr  <= Address[AW-1:0];
            r_wdata <= WriteData;
            r_width <= W_Enable ? W_Width : R_Width;
            r_we    <= W_Enable;
        end
    end

    always_ff @(posedge Clk) begin
        if (w_commit && w_sel_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_wmask[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
            end
        end
    end

    assign ReadData    = r_rdata;
    assign Valid       = r_valid;
    assign MisalignErr = r_misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: WAIT_STATES=2 instance for lane/alignment/reset cases,
// WAIT_STATES=0 instance for back-to-back traffic and address wrap-around.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_addr, a_wd, a_rd;
    logic        a_re, a_we, a_stall, a_valid, a_mis;
    logic [1:0]  a_rw, a_ww;
    logic [31:0] b_addr, b_wd, b_rd;
    logic        b_re, b_we, b_stall, b_valid, b_mis;
    logic [1:0]  b_rw, b_ww;

    int n_checks = 0;
    int n_fail   = 0;

    int          ns;
    logic        v, m;
    logic [31:0] rd;

    always #5 clk = ~clk;

    mem_access_unit #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_ws2 (
        .Clk(clk), .Rst(rst), .Address(a_addr), .WriteData(a_wd),
        .R_Enable(a_re), .W_Enable(a_we), .R_Width(a_rw), .W_Width(a_ww),
        .ReadData(a_rd), .Stall(a_stall), .Valid(a_valid), .MisalignErr(a_mis)
    );

    mem_access_unit #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
        .Clk(clk), .Rst(rst), .Address(b_addr), .WriteData(b_wd),
        .R_Enable(b_re), .W_Enable(b_we), .R_Width(b_rw), .W_Width(b_ww),
        .ReadData(b_rd), .Stall(b_stall), .Valid(b_valid), .MisalignErr(b_mis)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic a_drive(input logic re, input logic we, input logic [1:0] w,
                           input logic [31:0] addr, input logic [31:0] wd);
        a_re = re; a_we = we; a_rw = w; a_ww = w; a_addr = addr; a_wd = wd;
    endtask

    task automatic b_drive(input logic re, input logic we, input logic [1:0] w,
                           input logic [31:0] addr, input logic [31:0] wd);
        b_re = re; b_we = we; b_rw = w; b_ww = w; b_addr = addr; b_wd = wd;
    endtask

    // Holds the request while Stall is high, then samples the result cycle.
    task automatic a_access(input logic re, input logic we, input logic [1:0] w,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output int nstall, output logic ov, output logic om,
                            output logic [31:0] ord);
        @(posedge clk); #1;
        a_drive(re, we, w, addr, wd);
        nstall = 0;
        @(negedge clk);
        while (a_stall && nstall < 20) begin
            nstall++;
            @(negedge clk);
        end
        if (nstall == 0) begin
            @(posedge clk); #1;
            a_drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
            @(negedge clk);
        end
        ov = a_valid; om = a_mis; ord = a_rd;
        if (nstall != 0) begin
            @(posedge clk); #1;
            a_drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        b_drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rdata", a_rd, 32'h0);
        check("rst_valid", {31'b0, a_valid}, 32'h0);
        check("rst_mis",   {31'b0, a_mis},   32'h0);
        check("rst_stall", {31'b0, a_stall}, 32'h0);

        a_access(1'b0, 1'b1, 2'd0, 32'h10, 32'h11223344, ns, v, m, rd);
        check("sw_stall_cycles", ns, 2);
        check("sw_valid", {31'b0, v}, 32'h1);
        check("sw_mis",   {31'b0, m}, 32'h0);
        @(negedge clk);
        check("sw_valid_single", {31'b0, a_valid}, 32'h0);

        a_access(1'b1, 1'b0, 2'd0, 32'h10, 32'h0, ns, v, m, rd);
        check("lw10_stall", ns, 2);
        check("lw10_valid", {31'b0, v}, 32'h1);
        check("lw10_data", rd, 32'h11223344);

        a_access(1'b0, 1'b1, 2'd2, 32'h11, 32'h000000AB, ns, v, m, rd);
        check("sb_valid", {31'b0, v}, 32'h1);
        a_access(1'b1, 1'b0, 2'd0, 32'h10, 32'h0, ns, v, m, rd);
        check("lw_after_sb", rd, 32'h1122AB44);
        a_access(1'b1, 1'b0, 2'd2, 32'h11, 32'h0, ns, v, m, rd);
        check("lb11", rd, 32'hFFFFFFAB);
        a_access(1'b1, 1'b0, 2'd2, 32'h13, 32'h0, ns, v, m, rd);
        check("lb13", rd, 32'h00000011);

        a_access(1'b0, 1'b1, 2'd1, 32'h12, 32'h00008001, ns, v, m, rd);
        check("sh_stall", ns, 2);
        a_access(1'b1, 1'b0, 2'd0, 32'h10, 32'h0, ns, v, m, rd);
        check("lw_after_sh", rd, 32'h8001AB44);
        a_access(1'b1, 1'b0, 2'd1, 32'h12, 32'h0, ns, v, m, rd);
        check("lh12", rd, 32'hFFFF8001);
        a_access(1'b1, 1'b0, 2'd1, 32'h10, 32'h0, ns, v, m, rd);
        check("lh10", rd, 32'hFFFFAB44);

        a_access(1'b1, 1'b0, 2'd0, 32'h12, 32'h0, ns, v, m, rd);
        check("lw12_stall", ns, 0);
        check("lw12_mis",   {31'b0, m}, 32'h1);
        check("lw12_valid", {31'b0, v}, 32'h0);
        check("lw12_rdata", rd, 32'hFFFFAB44);
        @(negedge clk);
        check("lw12_mis_pulse", {31'b0, a_mis}, 32'h0);
        a_access(1'b1, 1'b0, 2'd1, 32'h13, 32'h0, ns, v, m, rd);
        check("lh13_stall", ns, 0);
        check("lh13_mis",   {31'b0, m}, 32'h1);
        check("lh13_valid", {31'b0, v}, 32'h0);
        check("lh13_rdata", rd, 32'hFFFFAB44);
        a_access(1'b1, 1'b0, 2'd3, 32'h10, 32'h0, ns, v, m, rd);
        check("w3_stall", ns, 0);
        check("w3_mis",   {31'b0, m}, 32'h1);
        check("w3_valid", {31'b0, v}, 32'h0);
        check("w3_rdata", rd, 32'hFFFFAB44);
        a_access(1'b1, 1'b1, 2'd0, 32'h10, 32'h0, ns, v, m, rd);
        check("both_en_mis",   {31'b0, m}, 32'h1);
        check("both_en_valid", {31'b0, v}, 32'h0);
        a_access(1'b0, 1'b1, 2'd0, 32'h11, 32'hFFFFFFFF, ns, v, m, rd);
        check("sw11_mis", {31'b0, m}, 32'h1);
        a_access(1'b1, 1'b0, 2'd0, 32'h10, 32'h0, ns, v, m, rd);
        check("sw11_no_write", rd, 32'h8001AB44);

        // Abort a store while it is in the wait state.
        @(posedge clk); #1;
        a_drive(1'b0, 1'b1, 2'd0, 32'h20, 32'hDEADBEEF);
        @(negedge clk);
        check("abort_stall_pre", {31'b0, a_stall}, 32'h1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        a_drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        check("abort_stall", {31'b0, a_stall}, 32'h0);
        check("abort_valid", {31'b0, a_valid}, 32'h0);
        check("abort_rdata", a_rd, 32'h0);
        a_access(1'b1, 1'b0, 2'd0, 32'h10, 32'h0, ns, v, m, rd);
        check("abort_keeps_mem", rd, 32'h8001AB44);
        a_access(1'b1, 1'b0, 2'd0, 32'h20, 32'h0, ns, v, m, rd);
        check("abort_no_write", rd, 32'h0);
        check("abort_lw_valid", {31'b0, v}, 32'h1);

        @(posedge clk); #1;
        b_drive(1'b0, 1'b1, 2'd0, 32'h40, 32'hCAFEF00D);
        @(negedge clk);
        check("ws0_c0_stall", {31'b0, b_stall}, 32'h0);
        @(posedge clk); #1;
        b_drive(1'b1, 1'b0, 2'd0, 32'h40, 32'h0);
        @(negedge clk);
        check("ws0_c1_stall", {31'b0, b_stall}, 32'h0);
        check("ws0_c1_valid", {31'b0, b_valid}, 32'h1);
        @(posedge clk); #1;
        b_drive(1'b0, 1'b1, 2'd0, 32'h44, 32'h12345678);
        @(negedge clk);
        check("ws0_c2_stall", {31'b0, b_stall}, 32'h0);
        check("ws0_c2_valid", {31'b0, b_valid}, 32'h1);
        check("ws0_c2_rdata", b_rd, 32'hCAFEF00D);
        @(posedge clk); #1;
        b_drive(1'b1, 1'b0, 2'd0, 32'h44, 32'h0);
        @(negedge clk);
        check("ws0_c3_stall", {31'b0, b_stall}, 32'h0);
        check("ws0_c3_valid", {31'b0, b_valid}, 32'h1);
        @(posedge clk); #1;
        b_drive(1'b1, 1'b0, 2'd0, 32'h1040, 32'h0);
        @(negedge clk);
        check("ws0_c4_stall", {31'b0, b_stall}, 32'h0);
        check("ws0_c4_valid", {31'b0, b_valid}, 32'h1);
        check("ws0_c4_rdata", b_rd, 32'h12345678);
        @(posedge clk); #1;
        b_drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        check("ws0_alias_valid", {31'b0, b_valid}, 32'h1);
        check("ws0_alias_rdata", b_rd, 32'hCAFEF00D);
        check("ws0_mis", {31'b0, b_mis}, 32'h0);
        @(negedge clk);
        check("ws0_idle_valid", {31'b0, b_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no completion expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory responder for the MEM stage. It consumes the controller's R_Enable, W_Enable, R_Width and W_Width, together with the ALU byte address and the rs2/rt store data.
- Performs word, half and byte loads and stores on an internal word-organised array. Lanes are little-endian; loads are sign-extended.
- Inserts a configurable number of wait states and raises Stall to freeze the pipeline while an access is in flight.
- Rejects misaligned or illegal requests without touching memory.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; must be a power of 2.
- WAIT_STATES, 1: stall cycles per legal access; allowed range 0..15.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Address  in  32  byte address from the ALU.
- WriteData  in  32  store data; the byte or half to store is in the low bits.
- R_Enable  in  1  load request.
- W_Enable  in  1  store request.
- R_Width  in  2  load width: 0 = word, 1 = half, 2 = byte, 3 = illegal.
- W_Width  in  2  store width, same encoding as R_Width.
- ReadData  out  32  registered, sign-extended load result.
- Stall  out  1  combinational; the pipeline holds every MEM-stage input stable while this is high.
- Valid  out  1  one-cycle pulse: the access completed (load data valid, or store committed).
- MisalignErr  out  1  one-cycle pulse: the request was rejected.

Behaviour:
- Reset:
  - state = IDLE, wait counter = 0.
  - ReadData = 0, Valid = 0, MisalignErr = 0, Stall = 0.
  - Array contents are not changed by Rst; they are zero at time 0.
- A request is "req" = R_Enable | W_Enable.
- A request is illegal when any of these hold:
  - both enables are high;
  - the active width = 3;
  - word access with Address[1:0] != 0;
  - half access with Address[0] != 0.
- Word index = Address[log2(DEPTH_WORDS)+1 : 2]. Upper address bits are ignored (wrap-around).
- Lanes:
  - byte k (k = Address[1:0]) is bits 8k+7 : 8k;
  - half at Address[1] = 0 is bits 15:0; half at Address[1] = 1 is bits 31:16.
- Stores write only the addressed lanes, using WriteData[7:0] for a byte and WriteData[15:0] for a half.
- "Commit" means, at a clock edge:
  - store: write the array;
  - load: ReadData <= sign-extended lane data.
- The cycle after any commit: Valid = 1. ReadData holds its value until the next load commit.
- State machine:
  - IDLE, no req: stay in IDLE; Valid = 0, MisalignErr = 0.
  - IDLE, illegal req:
    - no commit, Stall = 0, stay in IDLE;
    - MisalignErr = 1 in the next cycle;
    - ReadData unchanged.
  - IDLE, legal req, WAIT_STATES = 0: commit at this edge, stay in IDLE, Stall = 0. This supports back-to-back accesses.
  - IDLE, legal req, WAIT_STATES = 1: Stall = 1 this cycle; commit at this edge; go to DONE.
  - IDLE, legal req, WAIT_STATES >= 2:
    - Stall = 1; latch address, data, width and direction;
    - counter = WAIT_STATES - 2; go to WAIT.
  - WAIT: Stall = 1. Inputs are ignored; the latched copy is used.
    - counter = 0: commit and go to DONE.
    - otherwise: decrement the counter.
  - DONE:
    - Stall = 0, Valid = 1;
    - inputs are ignored, because they are the same held instruction;
    - go to IDLE next cycle.
- Net effect: Stall is high for exactly WAIT_STATES cycles per legal access. Valid is high in the first cycle that Stall is low after the commit.
- Rst asserted in WAIT or DONE: abort to IDLE; no commit; outputs return to their reset values.
- Valid and MisalignErr are never high in the same cycle.

Decomposition:
- mem_access_pkg holds:
  - width codes WIDTH_WORD = 2'd0, WIDTH_HALF = 2'd1, WIDTH_BYTE = 2'd2;
  - state encodings IDLE, WAIT, DONE;
  - the wait-counter width constant.
- mem_lane_align is one combinational sub-module. It:
  - takes width, Address[1:0], the read word and WriteData;
  - produces the sign-extended load value, a 4-bit byte write mask, the lane-replicated store word, and the misalign flag.
- The FSM, counter and array stay in mem_access_unit.

Test Plan:
- WAIT_STATES = 2, sw 0x11223344 @ 0x10 held under Stall:
  - Stall = 1 for 2 cycles, then Valid = 1 for 1 cycle;
  - a following lw @ 0x10 gives ReadData = 0x11223344;
  - only one write occurs despite the held inputs.
- Byte access:
  - sb 0x000000AB @ 0x11, then lw @ 0x10 gives 0x1122AB44;
  - lb @ 0x11 gives 0xFFFFFFAB;
  - lb @ 0x13 gives 0x00000011.
- Half access:
  - sh 0x00008001 @ 0x12, then lw @ 0x10 gives 0x8001AB44;
  - lh @ 0x12 gives 0xFFFF8001;
  - lh @ 0x10 gives 0xFFFFAB44.
- Illegal requests:
  - lw @ 0x12, lh @ 0x13 and R_Width = 3 each give: MisalignErr pulse, Stall = 0, Valid = 0, ReadData unchanged;
  - sw 0xFFFFFFFF @ 0x11 leaves the word @ 0x10 unchanged.
- Reset mid-access: Rst asserted in WAIT during sw 0xDEADBEEF @ 0x20 means no write; a later lw @ 0x20 gives 0x00000000.
- WAIT_STATES = 0:
  - alternating sw/lw to 0x40/0x44 on consecutive cycles gives Stall never high and Valid every cycle;
  - an address of DEPTH_WORDS*4 + 0x40 aliases to 0x40.
